// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, the clog2 helper and the status-flag
// record with its reset value, used by both the RX and TX FIFOs.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef struct packed {
    logic receive_full;
    logic fifo_full;
    logic almost_full;
    logic overflow;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{
    receive_full: 1'b0,
    fifo_full:    1'b0,
    almost_full:  1'b0,
    overflow:     1'b0
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port, cleared to zero on reset. Shared by the RX and TX FIFOs.
`timescale 1ns/1ps
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO: captures bytes on the active-low
// fifo_write strobe, pops on read_rx_byte, keeps registered status flags.
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = UART_DATA_WIDTH,
  parameter int AFULL_LEVEL = 12,
  localparam int AW         = clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_write,
  input  logic [WIDTH-1:0] rx_byte,
  input  logic             read_rx_byte,
  output logic [WIDTH-1:0] rx_data,
  output logic             receive_full,
  output logic             fifo_full,
  output logic             almost_full,
  output logic             overflow,
  output logic [CW-1:0]    rx_count
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_flags_t   flags_q, flags_d;

  logic wr, rd, wr_acc, rd_acc;

  assign wr = ~fifo_write;
  assign rd = read_rx_byte;
  // A write into a full FIFO is still accepted when a pop frees the slot.
  assign wr_acc = wr & (~flags_q.fifo_full | rd);
  assign rd_acc = rd & flags_q.receive_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the post-edge count so none of them lags rx_count.
    flags_d.receive_full = (count_d != '0);
    flags_d.fifo_full    = (count_d == DEPTH_CNT);
    flags_d.almost_full  = (count_d >= AFULL_CNT);

    if (wr & flags_q.fifo_full & ~rd) flags_d.overflow = 1'b1;
    else if (rd)                      flags_d.overflow = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FIFO_FLAGS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_byte),
    .raddr_i (rd_ptr_q),
    .rdata_o (rx_data)
  );

  assign receive_full = flags_q.receive_full;
  assign fifo_full    = flags_q.fifo_full;
  assign almost_full  = flags_q.almost_full;
  assign overflow     = flags_q.overflow;
  assign rx_count     = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue scoreboard holds expected bytes,
// a small count/overflow model predicts the flags after every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AFULL = 12;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             fifo_write = 1'b1;
  logic [WIDTH-1:0] rx_byte = '0;
  logic             read_rx_byte = 1'b0;
  logic [WIDTH-1:0] rx_data;
  logic             receive_full;
  logic             fifo_full;
  logic             almost_full;
  logic             overflow;
  logic [CW-1:0]    rx_count;

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] sb[$];
  int               m_cnt = 0;
  logic             m_ov = 1'b0;

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .WIDTH       (WIDTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_write   (fifo_write),
    .rx_byte      (rx_byte),
    .read_rx_byte (read_rx_byte),
    .rx_data      (rx_data),
    .receive_full (receive_full),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .rx_count     (rx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    check({ctx, ".rx_count"},     32'(rx_count),     32'(m_cnt));
    check({ctx, ".receive_full"}, 32'(receive_full), 32'(m_cnt != 0));
    check({ctx, ".fifo_full"},    32'(fifo_full),    32'(m_cnt == DEPTH));
    check({ctx, ".almost_full"},  32'(almost_full),  32'(m_cnt >= AFULL));
    check({ctx, ".overflow"},     32'(overflow),     32'(m_ov));
    if (m_cnt > 0) check({ctx, ".head"}, 32'(rx_data), 32'(sb[0]));
  endtask

  // One clock cycle with the given write/read request; model updated alongside.
  task automatic cycle(input string ctx, input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    int pre;
    logic wr_acc, rd_acc;
    logic [WIDTH-1:0] e;
    @(negedge clk);
    fifo_write   = ~wr;
    rx_byte      = d;
    read_rx_byte = rd;
    pre    = m_cnt;
    rd_acc = rd && (pre > 0);
    wr_acc = wr && ((pre < DEPTH) || rd);
    #1;
    if (rd_acc) begin
      e = sb.pop_front();
      check({ctx, ".pop"}, 32'(rx_data), 32'(e));
    end
    @(posedge clk);
    #1;
    if (wr_acc) sb.push_back(d);
    m_cnt = pre + int'(wr_acc) - int'(rd_acc);
    if (wr && (pre == DEPTH) && !rd) m_ov = 1'b1;
    else if (rd)                     m_ov = 1'b0;
    $display("txn %s wr=%0d data=%02h rd=%0d -> count=%0d head=%02h ovf=%0d",
             ctx, wr, d, rd, rx_count, rx_data, overflow);
    check_state(ctx);
    fifo_write   = 1'b1;
    read_rx_byte = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst.rx_data", 32'(rx_data), 32'h0);
    check_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Single byte
    cycle("single_wr", 1'b1, 8'hA5, 1'b0);
    cycle("single_rd", 1'b0, 8'h00, 1'b1);

    // Order and pointer wrap
    for (int i = 0; i < 16; i++) cycle("wrap_wr0", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) cycle("wrap_rd0", 1'b0, 8'h00, 1'b1);
    for (int i = 16; i < 32; i++) cycle("wrap_wr1", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) cycle("wrap_rd1", 1'b0, 8'h00, 1'b1);

    // Full, almost_full and overflow
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
    cycle("ovf_drop", 1'b1, 8'hEE, 1'b0);
    check("ovf_drop.head00", 32'(rx_data), 32'h00);
    cycle("ovf_clear", 1'b0, 8'h00, 1'b1);
    check("ovf_clear.head01", 32'(rx_data), 32'h01);

    // Simultaneous write and read while full
    cycle("refill", 1'b1, 8'h10, 1'b0);
    cycle("full_wr_rd", 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 8'h00, 1'b1);

    // Simultaneous write and read while empty
    cycle("empty_wr_rd", 1'b1, 8'h55, 1'b1);
    cycle("empty_wr_rd_pop", 1'b0, 8'h00, 1'b1);

    // Read on empty
    for (int i = 0; i < 3; i++) cycle("rd_empty", 1'b0, 8'h00, 1'b1);
    cycle("probe_wr", 1'b1, 8'h9B, 1'b0);
    cycle("probe_rd", 1'b0, 8'h00, 1'b1);

    // Reset mid-operation with data stored and overflow set
    for (int i = 0; i < 16; i++) cycle("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
    cycle("pre_rst_ovf", 1'b1, 8'hFF, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_cnt = 0;
    m_ov  = 1'b0;
    $display("txn async_reset -> count=%0d head=%02h ovf=%0d", rx_count, rx_data, overflow);
    check("async_rst.rx_data", 32'(rx_data), 32'h0);
    check_state("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    cycle("post_rst_wr", 1'b1, 8'h3C, 1'b0);
    check("post_rst.head3C", 32'(rx_data), 32'h3C);
    cycle("post_rst_rd", 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
